uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain controller directly upstream of the UART transmitter.
- The Hack CPU side pushes 16-bit words via a single-cycle write strobe; only bits [7:0] are stored.
- The drain FSM pops one byte at a time and issues it to the transmitter with a one-cycle LOAD pulse.
- It then tracks the transmitter's TX_BUSY until the byte completes, so the CPU can queue bursts without polling TX_BUSY per byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- CLK_100MHz  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- WR  input  1  push strobe; one push per cycle WR=1.
- IN  input  16  write data; IN[7:0] stored, IN[15:8] ignored.
- CLR_OVR  input  1  clears OVERRUN.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.
- COUNT  output  ADDR_W+1  entries held.
- OVERRUN  output  1  sticky: a push was dropped.
- STATUS  output  16  {11'b0, OVERRUN, FULL, EMPTY, DRAIN_ACTIVE, 1'b0}; CPU-readable word.
- LOAD  output  1  one-cycle issue pulse to the transmitter.
- DATA_OUT  output  16  {8'b0, byte}; valid while LOAD=1 and held until the next LOAD.
- TX_BUSY  input  1  transmitter busy, from the transmitter.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - Pointers 0, COUNT 0; EMPTY=1, FULL=0.
  - OVERRUN=0, LOAD=0, DATA_OUT=0.
  - FSM in IDLE; DRAIN_ACTIVE=0.
  - Reset mid-transmission discards all queued bytes. The in-flight transmitter byte is not affected.
- Storage: DEPTH x 8 register array. Write pointer and read pointer are ADDR_W bits and wrap modulo DEPTH. COUNT is tracked separately.
- Push: WR=1 and (not FULL, or a pop occurs in the same cycle) -> store IN[7:0] at wptr, increment wptr.
- Push while FULL with no same-cycle pop -> data dropped, OVERRUN set on that edge.
- Pop occurs only in the ISSUE cycle.
- Simultaneous push and pop: both take effect and COUNT is unchanged. When FULL, the push is accepted.
- OVERRUN clears on CLR_OVR=1. If CLR_OVR and a dropped push coincide, set wins.
- FSM (registered outputs):
  - IDLE: if not EMPTY and TX_BUSY=0 -> ISSUE. DRAIN_ACTIVE=0.
  - ISSUE (exactly 1 cycle): LOAD=1; DATA_OUT={8'b0, mem[rptr]}; rptr++, COUNT--; next WAIT_ACK.
  - WAIT_ACK: LOAD=0; stay until TX_BUSY=1, then WAIT_DONE. TX_BUSY rises one cycle after LOAD.
  - WAIT_DONE: stay until TX_BUSY=0, then IDLE.
  - DRAIN_ACTIVE=1 in ISSUE, WAIT_ACK and WAIT_DONE.
- Latency:
  - Push into an empty FIFO with an idle transmitter: LOAD is high on the 2nd edge after the WR edge (edge 1: write, edge 2: enter ISSUE).
  - Back-to-back bytes: next LOAD asserts 2 cycles after TX_BUSY falls.
- LOAD is never asserted while TX_BUSY=1 or while EMPTY. No pop occurs without a LOAD.
- FULL, EMPTY and COUNT reflect post-edge state; they are registered or derived from registered COUNT.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no data gap.

Test Plan:
- Reset, then WR IN=16'h1241 once -> one LOAD pulse with DATA_OUT=16'h0041. Model TX_BUSY high 1 cycle later for 8680 cycles -> FSM returns to IDLE and EMPTY=1.
- Push 0x01..0x05 back-to-back with a transmitter model -> five LOAD pulses in order 01..05. Each LOAD comes 2 cycles after TX_BUSY falls; never while TX_BUSY=1.
- Hold TX_BUSY=1 and push 17 bytes (DEPTH=16) -> FULL=1, COUNT=16, OVERRUN=1, 17th byte absent. CLR_OVR pulse -> OVERRUN=0.
- FULL FIFO with ISSUE and WR in the same cycle -> push accepted, COUNT stays 16, OVERRUN stays 0, output order preserved.
- Stream 40 bytes through DEPTH=16 with random WR gaps -> output sequence matches input. Pointers wrap at least twice.
- Assert RESET_N=0 asynchronously while COUNT=7 and in WAIT_DONE -> outputs go to reset values immediately, no further LOAD, EMPTY=1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO feeding the UART transmitter, with a drain FSM that issues
//           one byte per LOAD pulse and follows TX_BUSY until that byte completes.
// Latency : WR into an empty FIFO with an idle transmitter -> LOAD on the 2nd edge
//           after the WR edge; next LOAD 2 cycles after TX_BUSY falls.
// Backpr. : no stall to the CPU; a push while FULL (no same-cycle pop) is dropped
//           and sets sticky OVERRUN until CLR_OVR.
//
// Ports:
//   CLK_100MHz, RESET_N     clock, asynchronous active-low reset
//   WR, IN[15:0]            push strobe and data (IN[7:0] stored)
//   CLR_OVR                 clears OVERRUN (a same-cycle drop wins)
//   FULL, EMPTY, COUNT      occupancy, derived from the registered count
//   OVERRUN                 sticky dropped-push flag
//   STATUS[15:0]            {11'b0, OVERRUN, FULL, EMPTY, DRAIN_ACTIVE, 1'b0}
//   LOAD, DATA_OUT[15:0]    one-cycle issue pulse and {8'b0, byte}, held until next LOAD
//   TX_BUSY                 transmitter busy, rises one cycle after LOAD
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK_100MHz,
  input  logic              RESET_N,
  input  logic              WR,
  input  logic [15:0]       IN,
  input  logic              CLR_OVR,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERRUN,
  output logic [15:0]       STATUS,
  output logic              LOAD,
  output logic [15:0]       DATA_OUT,
  input  logic              TX_BUSY
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              drain_active;
  logic              load_q;
  logic [15:0]       data_out_q;
  state_t            state;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Upper half of the CPU word carries nothing for the transmitter.
  logic unused_in_hi;
  assign unused_in_hi = ^IN[15:8];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // The byte leaves the FIFO at the end of the ISSUE cycle; DATA_OUT was
  // already captured on entry to ISSUE, so a same-cycle push into a full
  // FIFO may safely overwrite the slot being vacated.
  assign pop  = (state == ISSUE);
  assign push = WR && (!full || pop);
  assign drop = WR && full && !pop;

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge CLK_100MHz) begin
    if (push) begin
      mem[wptr] <= IN[7:0];
    end
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (CLR_OVR) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      load_q       <= 1'b0;
      data_out_q   <= '0;
      drain_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_q <= 1'b0;
          if (!empty && !TX_BUSY) begin
            state        <= ISSUE;
            load_q       <= 1'b1;
            data_out_q   <= {8'h00, mem[rptr]};
            drain_active <= 1'b1;
          end else begin
            drain_active <= 1'b0;
          end
        end
        ISSUE: begin
          load_q <= 1'b0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          load_q <= 1'b0;
          if (TX_BUSY) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          load_q <= 1'b0;
          if (!TX_BUSY) begin
            state        <= IDLE;
            drain_active <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          load_q       <= 1'b0;
          drain_active <= 1'b0;
        end
      endcase
    end
  end

  assign FULL     = full;
  assign EMPTY    = empty;
  assign COUNT    = count;
  assign OVERRUN  = overrun;
  assign LOAD     = load_q;
  assign DATA_OUT = data_out_q;
  assign STATUS   = {11'b0, overrun, full, empty, drain_active, 1'b0};

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic        CLK_100MHz = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        WR         = 1'b0;
  logic [15:0] IN         = '0;
  logic        CLR_OVR    = 1'b0;
  logic        FULL;
  logic        EMPTY;
  logic [4:0]  COUNT;
  logic        OVERRUN;
  logic [15:0] STATUS;
  logic        LOAD;
  logic [15:0] DATA_OUT;
  logic        tx_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .CLK_100MHz(CLK_100MHz),
    .RESET_N   (RESET_N),
    .WR        (WR),
    .IN        (IN),
    .CLR_OVR   (CLR_OVR),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERRUN   (OVERRUN),
    .STATUS    (STATUS),
    .LOAD      (LOAD),
    .DATA_OUT  (DATA_OUT),
    .TX_BUSY   (tx_busy)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  int cmp_n = 0;
  int err_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: busy for tx_left cycles after each LOAD.
  bit  force_busy = 1'b0;
  int  tx_left    = 0;
  int  tx_len     = 4;
  bit  tx_rand    = 1'b0;
  assign tx_busy = force_busy || (tx_left != 0);

  // Reference model: queue of accepted bytes plus a drain tracker that
  // issues a byte when idle, waits for the transmitter to go busy, then idle.
  logic [7:0] mq[$];
  bit         m_issue, m_drain, m_seen, m_ovr;
  logic [7:0] m_dout;

  always @(posedge CLK_100MHz or negedge RESET_N) begin
    bit pop, acc, start;
    if (!RESET_N) begin
      mq.delete();
      m_issue = 0; m_drain = 0; m_seen = 0; m_ovr = 0; m_dout = 8'h00;
    end else begin
      start = !m_issue && !m_drain && (mq.size() != 0) && !tx_busy;
      pop   = m_issue;
      acc   = WR && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(IN[7:0]);
      if (WR && !acc) m_ovr = 1;
      else if (CLR_OVR) m_ovr = 0;
      if (pop) begin
        m_issue = 0; m_drain = 1; m_seen = 0;
      end else if (m_drain) begin
        if (!m_seen && tx_busy) m_seen = 1;
        else if (m_seen && !tx_busy) m_drain = 0;
      end else if (start) begin
        m_issue = 1;
        m_dout  = mq[0];
      end
    end
  end

  int         cyc = 0;
  int         fall_cyc = 0;
  int         last_load_cyc = 0;
  int         load_n = 0;
  bit         chk_gap = 0;
  logic [7:0] log_q[$];

  // Compare process plus transmitter response, all away from the rising edge.
  always @(negedge CLK_100MHz) begin
    int old_left;
    cyc++;
    check("count",    32'(COUNT),    32'(mq.size()));
    check("full",     32'(FULL),     32'(mq.size() == DEPTH));
    check("empty",    32'(EMPTY),    32'(mq.size() == 0));
    check("overrun",  32'(OVERRUN),  32'(m_ovr));
    check("load",     32'(LOAD),     32'(m_issue));
    check("data_out", 32'(DATA_OUT), 32'({8'h00, m_dout}));
    check("status",   32'(STATUS),
          32'({11'b0, m_ovr, mq.size() == DEPTH, mq.size() == 0, m_issue || m_drain, 1'b0}));
    if (LOAD) begin
      check("load_while_busy",  32'(tx_busy), 32'(0));
      check("load_while_empty", 32'(EMPTY),   32'(0));
      log_q.push_back(DATA_OUT[7:0]);
      if (chk_gap && fall_cyc > last_load_cyc) check("busy_fall_to_load", 32'(cyc - fall_cyc), 32'(2));
      last_load_cyc = cyc;
      load_n++;
    end
    old_left = tx_left;
    if (tx_left > 0) tx_left--;
    if (old_left != 0 && tx_left == 0) fall_cyc = cyc;
    if (LOAD) tx_left = tx_rand ? int'($urandom_range(2, 6)) : tx_len;
  end

  task automatic push(input logic [15:0] d);
    WR = 1'b1; IN = d;
    @(negedge CLK_100MHz);
    WR = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while (!(mq.size() == 0 && !m_issue && !m_drain && tx_left == 0) && n < max_cyc) begin
      @(negedge CLK_100MHz);
      n++;
    end
    if (n >= max_cyc) check({name, "_timeout"}, 32'(1), 32'(0));
  endtask

  initial begin
    int n;
    int loads_before;

    // Reset state
    repeat (3) @(negedge CLK_100MHz);
    check("rst_count",  32'(COUNT),    32'(0));
    check("rst_status", 32'(STATUS),   32'h0004);
    check("rst_dout",   32'(DATA_OUT), 32'(0));
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK_100MHz);

    // Single byte, slow transmitter
    tx_len = 8680;
    WR = 1'b1; IN = 16'h1241;
    @(negedge CLK_100MHz);
    WR = 1'b0;
    check("t1_load_edge1", 32'(LOAD), 32'(0));
    @(negedge CLK_100MHz);
    check("t1_load_edge2", 32'(LOAD), 32'(1));
    check("t1_data",       32'(DATA_OUT), 32'h0041);
    wait_drain(9000, "t1");
    @(negedge CLK_100MHz);
    check("t1_empty",  32'(EMPTY),  32'(1));
    check("t1_status", 32'(STATUS), 32'h0004);

    // Five bytes back to back, LOAD 2 cycles after each busy fall
    tx_len = 6;
    log_q.delete();
    fall_cyc = 0;
    chk_gap = 1;
    for (int i = 1; i <= 5; i++) push(16'(i) | 16'hAB00);
    wait_drain(200, "t2");
    chk_gap = 0;
    check("t2_nloads", 32'(log_q.size()), 32'(5));
    for (int i = 0; i < 5 && i < log_q.size(); i++) check("t2_order", 32'(log_q[i]), 32'(i + 1));

    // Fill past full while the transmitter is held busy
    force_busy = 1'b1;
    log_q.delete();
    for (int i = 0; i < 17; i++) push(16'h8080 + 16'(i));
    check("t3_count",   32'(COUNT),   32'(16));
    check("t3_full",    32'(FULL),    32'(1));
    check("t3_overrun", 32'(OVERRUN), 32'(1));
    CLR_OVR = 1'b1;
    @(negedge CLK_100MHz);
    CLR_OVR = 1'b0;
    check("t3_clr", 32'(OVERRUN), 32'(0));

    // Push during the ISSUE cycle of a full FIFO
    tx_len = 4;
    force_busy = 1'b0;
    n = 0;
    while (!LOAD && n < 20) begin
      @(negedge CLK_100MHz);
      n++;
    end
    check("t4_load_seen", 32'(LOAD), 32'(1));
    push(16'hFFA5);
    check("t4_count",   32'(COUNT),   32'(16));
    check("t4_overrun", 32'(OVERRUN), 32'(0));
    wait_drain(500, "t4");
    check("t4_nloads", 32'(log_q.size()), 32'(17));
    if (log_q.size() == 17) begin
      check("t4_last_kept", 32'(log_q[15]), 32'h8F);
      check("t4_pushed",    32'(log_q[16]), 32'hA5);
    end

    // Random stream with gaps and random transmit lengths
    tx_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK_100MHz);
      push({8'($urandom), 8'($urandom)});
    end
    wait_drain(2000, "t5");
    tx_rand = 1'b0;

    // Asynchronous reset with 7 queued bytes and a byte in flight
    tx_len = 200;
    for (int i = 0; i < 8; i++) push(16'h0030 + 16'(i));
    repeat (20) @(negedge CLK_100MHz);
    check("t6_pre_count", 32'(COUNT),     32'(7));
    check("t6_pre_drain", 32'(STATUS[1]), 32'(1));
    @(posedge CLK_100MHz);
    #3 RESET_N = 1'b0;
    #1;
    check("t6_count",  32'(COUNT),    32'(0));
    check("t6_empty",  32'(EMPTY),    32'(1));
    check("t6_load",   32'(LOAD),     32'(0));
    check("t6_dout",   32'(DATA_OUT), 32'(0));
    check("t6_status", 32'(STATUS),   32'h0004);
    loads_before = load_n;
    repeat (2) @(negedge CLK_100MHz);
    RESET_N = 1'b1;
    repeat (30) @(negedge CLK_100MHz);
    check("t6_no_load",   32'(load_n), 32'(loads_before));
    check("t6_empty_end", 32'(EMPTY),  32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
